hci_ecc_stream_source: RTL

- Parametrised, ECC-aware TCDM-to-stream source engine for HWPE datapaths.
- Generates a strided read sequence on a flattened TCDM initiator port with up to MAX_OUTSTANDING requests in flight.
- Decodes SECDED (extended Hamming) on every response and delivers corrected words, in order, on a valid/ready stream.
- Reports correctable/uncorrectable errors per word plus sticky status; sits between the streamer controller and the interconnect.

---
 rtl/hci_ecc_stream_source.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/hci_ecc_stream_source.sv
// hci_ecc_stream_source
//   Strided TCDM read engine with SECDED (extended Hamming) decode feeding an
//   in-order valid/ready stream. Up to MAX_OUTSTANDING reads are in flight. Each
//   request reserves a response FIFO slot, so responses are never dropped for
//   lack of space.
//
//   Ports
//     clk_i, rst_i (async, active high), clear_i (sync abort/flush)
//     start_i, base_addr_i, stride_i, len_i : job setup, sampled in IDLE
//     busy_o, done_o                         : job status
//     tcdm_*                                 : flattened TCDM read initiator
//     stream_*                               : corrected data + {ue, ce} flags
//     sticky_ue_o, ce_count_o, ue_count_o    : error status, cleared on start
//
//   ECC layout: the code is a Hamming code over positions 1..DW+EW-1. Hamming
//   parity bit i sits at position 2^i and is carried in ecc[i]. Data bit j sits
//   at the j-th non-power-of-two position. ecc[EW-1] makes the XOR of all
//   data and ecc bits equal to zero.
//
//   Optional: define HCI_ECC_STREAM_SOURCE_ERR_CNT_EN to build the saturating
//   ce/ue word counters. Without it, both counter outputs are tied to zero.
module hci_ecc_stream_source #(
    parameter int unsigned DW              = 32,
    parameter int unsigned AW              = 32,
    parameter int unsigned LW              = 16,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = 16,
    localparam int unsigned EW             = $clog2(DW) + 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [AW-1:0]    base_addr_i,
    input  logic [AW-1:0]    stride_i,
    input  logic [LW-1:0]    len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             tcdm_req_o,
    input  logic             tcdm_gnt_i,
    output logic [AW-1:0]    tcdm_add_o,
    output logic             tcdm_wen_o,
    output logic [DW/8-1:0]  tcdm_be_o,
    input  logic             tcdm_r_valid_i,
    input  logic [DW-1:0]    tcdm_r_data_i,
    input  logic [EW-1:0]    tcdm_r_ecc_i,
    output logic [DW-1:0]    stream_data_o,
    output logic [1:0]       stream_err_o,
    output logic             stream_valid_o,
    input  logic             stream_ready_i,
    output logic             sticky_ue_o,
    output logic [CNT_W-1:0] ce_count_o,
    output logic [CNT_W-1:0] ue_count_o
);
    localparam int unsigned R  = EW - 1;                       // Hamming parity bits
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);  // holds 0..MAX
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Codeword position of data bit j (j-th non-power-of-two position >= 3).
    function automatic logic [R-1:0] data_pos(input int unsigned j);
        int unsigned n;
        data_pos = '0;
        n        = 0;
        for (int unsigned p = 3; p <= DW + R; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == j) data_pos = R'(p);
                n++;
            end
        end
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, stride_q, stride_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [OW-1:0] outst_q, outst_d, drop_q, drop_d, occ_q, occ_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic          sticky_q, sticky_d, done0_q, done0_d;
    logic [DW+1:0] mem_q [MAX_OUTSTANDING];

    // SECDED decode, purely combinational on the response bus.
    logic [R-1:0]  syn;
    logic          par;
    logic [DW-1:0] dec_data;
    logic [1:0]    dec_err;

    always_comb begin
        syn = tcdm_r_ecc_i[R-1:0];
        for (int unsigned j = 0; j < DW; j++)
            if (tcdm_r_data_i[j]) syn = syn ^ data_pos(j);
        par      = ^{tcdm_r_data_i, tcdm_r_ecc_i};
        dec_data = tcdm_r_data_i;
        dec_err  = 2'b00;
        if (par) begin
            // Odd parity: single flip, unless the syndrome points outside the word.
            if (syn > R'(DW + R)) begin
                dec_err = 2'b10;
            end else begin
                dec_err = 2'b01;
                for (int unsigned j = 0; j < DW; j++)
                    if (syn == data_pos(j)) dec_data[j] = ~tcdm_r_data_i[j];
            end
        end else if (syn != '0) begin
            dec_err = 2'b10;
        end
    end

    logic start_ok, start_go, gnt_ok, rsp_ok, rsp_drop, push, pop, drain_done;

    // Slot reservation: in-flight + buffered words never exceed the FIFO depth.
    assign tcdm_req_o = (state_q == S_ISSUE) && !clear_i &&
                        (({1'b0, outst_q} + {1'b0, occ_q}) < (OW+1)'(MAX_OUTSTANDING));
    assign gnt_ok     = tcdm_req_o && tcdm_gnt_i;
    assign rsp_drop   = tcdm_r_valid_i && (drop_q != '0);
    // Responses with nothing outstanding are protocol violations and are ignored.
    assign rsp_ok     = tcdm_r_valid_i && (drop_q == '0) && (outst_q != '0);
    assign push       = rsp_ok && !clear_i;
    assign pop        = stream_valid_o && stream_ready_i && !clear_i;
    assign start_ok   = (state_q == S_IDLE) && (drop_q == '0) && start_i && !clear_i;
    assign start_go   = start_ok && (len_i != '0);
    assign drain_done = (state_q == S_DRAIN) && (outst_q == '0) && (occ_q == '0);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        rem_d    = rem_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
        occ_d    = occ_q + OW'(push) - OW'(pop);
        rd_d     = pop  ? ptr_inc(rd_q) : rd_q;
        wr_d     = push ? ptr_inc(wr_q) : wr_q;
        sticky_d = sticky_q | (push & dec_err[1]);
        done0_d  = 1'b0;

        if (gnt_ok && !rsp_ok)      outst_d = outst_q + OW'(1);
        else if (!gnt_ok && rsp_ok) outst_d = outst_q - OW'(1);
        if (rsp_drop) drop_d = drop_q - OW'(1);

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    if (len_i == '0) begin
                        done0_d = 1'b1;
                    end else begin
                        addr_d   = base_addr_i;
                        stride_d = stride_i;
                        rem_d    = len_i;
                        sticky_d = 1'b0;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (gnt_ok) begin
                    addr_d = addr_q + stride_q;
                    rem_d  = rem_q - LW'(1);
                    if (rem_q == LW'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (drain_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort: whatever is still in flight gets counted off as it returns.
        if (clear_i) begin
            state_d = S_IDLE;
            outst_d = '0;
            occ_d   = '0;
            rd_d    = '0;
            wr_d    = '0;
            drop_d  = drop_q + outst_q -
                      OW'(tcdm_r_valid_i && ((drop_q != '0) || (outst_q != '0)));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            rem_q    <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
            occ_q    <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            sticky_q <= 1'b0;
            done0_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            rem_q    <= rem_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            occ_q    <= occ_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            sticky_q <= sticky_d;
            done0_q  <= done0_d;
        end
    end

    // Storage needs no reset; the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= {dec_err, dec_data};
    end

    assign stream_valid_o = (occ_q != '0);
    assign {stream_err_o, stream_data_o} = stream_valid_o ? mem_q[rd_q] : '0;

    assign busy_o      = (state_q != S_IDLE) || (drop_q != '0);
    assign done_o      = done0_q || (drain_done && !clear_i);
    assign tcdm_add_o  = addr_q;
    assign tcdm_wen_o  = 1'b1;
    assign tcdm_be_o   = '1;
    assign sticky_ue_o = sticky_q;

`ifdef HCI_ECC_STREAM_SOURCE_ERR_CNT_EN
    logic [CNT_W-1:0] ce_q, ue_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ce_q <= '0;
            ue_q <= '0;
        end else if (start_go) begin
            ce_q <= '0;
            ue_q <= '0;
        end else if (pop) begin
            if (stream_err_o[0] && (ce_q != '1)) ce_q <= ce_q + CNT_W'(1);
            if (stream_err_o[1] && (ue_q != '1)) ue_q <= ue_q + CNT_W'(1);
        end
    end

    assign ce_count_o = ce_q;
    assign ue_count_o = ue_q;
`else
    assign ce_count_o = '0;
    assign ue_count_o = '0;
`endif

endmodule
